// File: rtl/kernel3_srl_ctrl_pkg.sv
// Shared types for the gmem_C m_axi SRL FIFO controller.
// Holds the one-hot occupancy state and the occupancy counter width helper.
package kernel3_srl_ctrl_pkg;

    typedef enum logic [2:0] {
        S_EMPTY = 3'b001,
        S_MID   = 3'b010,
        S_FULL  = 3'b100
    } srl_state_t;

    // Occupancy counters share the num_data width: one bit wider than raddr.
    function automatic int occ_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/kernel3_srl_ctrl_cnt.sv
// Saturating up/down occupancy counter with synchronous clear.
// Exposes the next value so callers can register state derived from it.
module kernel3_srl_ctrl_cnt #(
    parameter int W   = 7,
    parameter int MAX = 62
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt
);

    localparam logic [W-1:0] MAXV = W'(MAX);
    localparam logic [W-1:0] ONE  = W'(1);

    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (inc && !dec && cnt != MAXV)
            cnt_nxt = cnt + ONE;
        else if (dec && !inc && cnt != '0)
            cnt_nxt = cnt - ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/kernel3_gmem_c_m_axi_srl_ctrl.sv
// Control path for the gmem_C SRL FIFO: SRL entries plus one output register.
// Occupancy statistics (hwm, overflow_attempt) exist only with KERNEL3_SRL_CTRL_STATS_EN.
module kernel3_gmem_c_m_axi_srl_ctrl
    import kernel3_srl_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 63,
    parameter int AF_LEVEL   = DEPTH - 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  srl_clk_en,
    output logic                  srl_we,
    output logic                  srl_re,
    output logic [ADDR_WIDTH-1:0] srl_raddr,
    output logic [ADDR_WIDTH:0]   num_data,
`ifdef KERNEL3_SRL_CTRL_STATS_EN
    output logic [ADDR_WIDTH:0]   hwm,
    output logic                  overflow_attempt,
`endif
    output logic                  almost_full
);

    localparam int CW = occ_w(ADDR_WIDTH);
    localparam logic [CW-1:0] FULLV = CW'(DEPTH - 1);
    localparam logic [CW-1:0] AFV   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] ONE   = CW'(1);

    if (DEPTH < 2 || DATA_WIDTH < 1) begin : g_param_chk
        $error("kernel3 srl ctrl: bad DEPTH/DATA_WIDTH");
    end

    srl_state_t    state;
    srl_state_t    state_nxt;
    logic          run;
    logic          out_vld;
    logic          out_vld_nxt;
    logic          push;
    logic          pop;
    logic          wr;
    logic          rd;
    logic [CW-1:0] used;
    logic [CW-1:0] used_nxt;
    logic [CW-1:0] num_nxt;
    logic [CW-1:0] raddr_w;

    // run holds s_ready low until the first edge after reset release
    assign s_ready    = run & (state != S_FULL);
    assign push       = s_valid & s_ready;
    assign pop        = (used != '0) & (~out_vld | m_ready);
    assign wr         = push & ~flush;
    assign rd         = pop & ~flush;
    assign srl_we     = wr;
    assign srl_re     = rd;
    assign srl_clk_en = run;
    assign m_valid    = out_vld;

    assign raddr_w   = (used == '0) ? '0 : used - ONE;
    assign srl_raddr = raddr_w[ADDR_WIDTH-1:0];

    assign num_data    = used + CW'(out_vld);
    assign out_vld_nxt = ~flush & (rd | (out_vld & ~m_ready));
    assign num_nxt     = used_nxt + CW'(out_vld_nxt);

    kernel3_srl_ctrl_cnt #(
        .W   (CW),
        .MAX (DEPTH - 1)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (wr),
        .dec     (rd),
        .cnt     (used),
        .cnt_nxt (used_nxt)
    );

    always_comb begin
        state_nxt = S_MID;
        unique case (1'b1)
            (used_nxt == '0):    state_nxt = S_EMPTY;
            (used_nxt == FULLV): state_nxt = S_FULL;
            default:             state_nxt = S_MID;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run         <= 1'b0;
            state       <= S_EMPTY;
            out_vld     <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            run         <= 1'b1;
            state       <= state_nxt;
            out_vld     <= out_vld_nxt;
            almost_full <= ~flush & (num_nxt >= AFV);
        end
    end

`ifdef KERNEL3_SRL_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hwm              <= '0;
            overflow_attempt <= 1'b0;
        end else begin
            if (flush)
                hwm <= '0;
            else if (num_nxt > hwm)
                hwm <= num_nxt;
            if (run && s_valid && state == S_FULL)
                overflow_attempt <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_kernel3_gmem_c_m_axi_srl_ctrl.sv
// Scoreboard bench for the SRL FIFO controller, DEPTH=4.
// Models the SRL datapath from the DUT strobes and checks FIFO order.
module tb_kernel3_gmem_c_m_axi_srl_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DW    = 32;
    localparam int AF    = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic          m_valid;
    logic          m_ready;
    logic          srl_clk_en;
    logic          srl_we;
    logic          srl_re;
    logic [AW-1:0] srl_raddr;
    logic [AW:0]   num_data;
    logic          almost_full;
`ifdef KERNEL3_SRL_CTRL_STATS_EN
    logic [AW:0]   hwm;
    logic          overflow_attempt;
`endif

    logic [DW-1:0] srl_m [DEPTH-1];
    logic [DW-1:0] dout;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] seq;
    int            n_chk;
    int            n_fail;

    always #5 clk = ~clk;

    kernel3_gmem_c_m_axi_srl_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush            (flush),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .srl_clk_en       (srl_clk_en),
        .srl_we           (srl_we),
        .srl_re           (srl_re),
        .srl_raddr        (srl_raddr),
        .num_data         (num_data),
`ifdef KERNEL3_SRL_CTRL_STATS_EN
        .hwm              (hwm),
        .overflow_attempt (overflow_attempt),
`endif
        .almost_full      (almost_full)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, settle, model the edge, end 1 after posedge.
    task automatic cycle(input logic sv, input logic [DW-1:0] sd,
                         input logic mr);
        logic [DW-1:0] rd_v;
        logic [DW-1:0] e;
        @(negedge clk);
        s_valid = sv;
        m_ready = mr;
        flush   = 1'b0;
        #1;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("data", 64'(dout), 64'(e));
            end
        end
        rd_v = dout;
        if (srl_re)
            rd_v = srl_m[srl_raddr];
        if (srl_we) begin
            for (int i = DEPTH - 2; i > 0; i--)
                srl_m[i] = srl_m[i-1];
            srl_m[0] = sd;
        end
        if (sv && s_ready)
            exp_q.push_back(sd);
        dout = rd_v;
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, seq, 1'b0);
            seq++;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (num_data != 0 && n < budget) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        check_eq("drain_empty", 64'(num_data), 64'd0);
        check_eq("drain_q", 64'(exp_q.size()), 64'd0);
        check_eq("drain_mvalid", 64'(m_valid), 64'd0);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        seq     = 32'hA000_0000;
        dout    = '0;
        reset_n = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++)
            srl_m[i] = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_s_ready", 64'(s_ready), 64'd0);
        check_eq("rst_m_valid", 64'(m_valid), 64'd0);
        check_eq("rst_num", 64'(num_data), 64'd0);
        check_eq("rst_clk_en", 64'(srl_clk_en), 64'd0);
        check_eq("rst_af", 64'(almost_full), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("rel_s_ready_pre", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        check_eq("rel_s_ready", 64'(s_ready), 64'd1);
        check_eq("rel_clk_en", 64'(srl_clk_en), 64'd1);

        // single push: no bypass, read at cycle 1, valid at cycle 2
        cycle(1'b1, seq, 1'b0);
        seq++;
        check_eq("sp_re", 64'(srl_re), 64'd1);
        check_eq("sp_raddr", 64'(srl_raddr), 64'd0);
        check_eq("sp_mvalid1", 64'(m_valid), 64'd0);
        cycle(1'b0, '0, 1'b0);
        check_eq("sp_mvalid2", 64'(m_valid), 64'd1);
        check_eq("sp_num", 64'(num_data), 64'd1);
        drain(4);

        // fill to full with m_ready low
        cycle(1'b1, seq, 1'b0);
        seq++;
        check_eq("f1_num", 64'(num_data), 64'd1);
        check_eq("f1_af", 64'(almost_full), 64'd0);
        cycle(1'b1, seq, 1'b0);
        seq++;
        check_eq("f2_num", 64'(num_data), 64'd2);
        check_eq("f2_af", 64'(almost_full), 64'd0);
        cycle(1'b1, seq, 1'b0);
        seq++;
        check_eq("f3_num", 64'(num_data), 64'd3);
        check_eq("f3_af", 64'(almost_full), 64'd1);
        check_eq("f3_s_ready", 64'(s_ready), 64'd1);
        cycle(1'b1, seq, 1'b0);
        seq++;
        check_eq("f4_num", 64'(num_data), 64'd4);
        check_eq("f4_s_ready", 64'(s_ready), 64'd0);
        check_eq("f4_raddr", 64'(srl_raddr), 64'd2);
        // push attempt while full is ignored
        cycle(1'b1, seq, 1'b0);
        seq++;
        check_eq("ovf_num", 64'(num_data), 64'd4);
        check_eq("ovf_we", 64'(srl_we), 64'd0);
`ifdef KERNEL3_SRL_CTRL_STATS_EN
        check_eq("ovf_sticky", 64'(overflow_attempt), 64'd1);
        check_eq("hwm_full", 64'(hwm), 64'd4);
`endif
        // drain in DEPTH cycles
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, '0, 1'b1);
        check_eq("dr_mvalid", 64'(m_valid), 64'd0);
        check_eq("dr_num", 64'(num_data), 64'd0);
        check_eq("dr_s_ready", 64'(s_ready), 64'd1);
        check_eq("dr_q", 64'(exp_q.size()), 64'd0);

        // steady push+pop with used=2
        push_n(3);
        check_eq("ss_num0", 64'(num_data), 64'd3);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, seq, 1'b1);
            seq++;
            check_eq("ss_num", 64'(num_data), 64'd3);
            check_eq("ss_raddr", 64'(srl_raddr), 64'd1);
        end
        drain(8);

        // flush with push and pop asserted
        push_n(3);
        @(negedge clk);
        s_valid = 1'b1;
        m_ready = 1'b1;
        flush   = 1'b1;
        #1;
        check_eq("fl_we", 64'(srl_we), 64'd0);
        check_eq("fl_re", 64'(srl_re), 64'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        flush   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        check_eq("fl_num", 64'(num_data), 64'd0);
        check_eq("fl_mvalid", 64'(m_valid), 64'd0);
        check_eq("fl_af", 64'(almost_full), 64'd0);
`ifdef KERNEL3_SRL_CTRL_STATS_EN
        check_eq("fl_hwm", 64'(hwm), 64'd0);
`endif
        push_n(2);
        drain(6);

        // asynchronous reset mid-stream with used=3
        push_n(4);
        check_eq("mr_num", 64'(num_data), 64'd4);
        @(negedge clk);
        s_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("ar_s_ready", 64'(s_ready), 64'd0);
        check_eq("ar_mvalid", 64'(m_valid), 64'd0);
        check_eq("ar_num", 64'(num_data), 64'd0);
        check_eq("ar_we", 64'(srl_we), 64'd0);
        check_eq("ar_re", 64'(srl_re), 64'd0);
        check_eq("ar_clk_en", 64'(srl_clk_en), 64'd0);
        check_eq("ar_raddr", 64'(srl_raddr), 64'd0);
        check_eq("ar_af", 64'(almost_full), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("ar_s_ready_pre", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        check_eq("ar_s_ready_post", 64'(s_ready), 64'd1);
        check_eq("ar_num_post", 64'(num_data), 64'd0);
        s_valid = 1'b0;

        // traffic after reset still in order
        push_n(2);
        drain(6);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
